alu_core: RTL and testbench

- Registered, single-cycle-latency arithmetic/logic unit: two unsigned WIDTH-bit operands (A, B) and a 4-bit opcode (Op) produce a 2*WIDTH-bit Result.
- Sits behind the ALU bus interface; the interface-driven stimulus program drives A/B/Op and samples Result on the interface clock.
- Purely synchronous: one clock, no handshake, a new operation may be issued every cycle.

---
 rtl/alu_core.sv | 98 +++++++++
 tb/tb_alu_core.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
//   Registered arithmetic/logic unit with one cycle of latency. Two unsigned
//   WIDTH-bit operands and a 4-bit opcode produce a 2*WIDTH-bit result. A new
//   operation can be issued on every clock edge.
//
// Ports
//   clk     in   1          system clock, rising edge
//   reset   in   1          synchronous reset, active low
//   A       in   WIDTH      operand A, unsigned
//   B       in   WIDTH      operand B, unsigned
//   Op      in   4          operation select (see opcode localparams)
//   Result  out  2*WIDTH    registered result
// ----------------------------------------------------------------------------
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           Op,
    output logic [2*WIDTH-1:0]   Result
);

    localparam int RW  = 2 * WIDTH;
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_ROL  = 4'd12;
    localparam logic [3:0] OP_ROR  = 4'd13;
    localparam logic [3:0] OP_EQ   = 4'd14;
    localparam logic [3:0] OP_GT   = 4'd15;

    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    logic [SHW-1:0]   sh;
    logic [RW-1:0]    dbl;
    logic [RW-1:0]    rol_full;
    logic [RW-1:0]    ror_full;
    logic [RW-1:0]    result_d;
    logic [RW-1:0]    result_q;

    assign a_ext = {{WIDTH{1'b0}}, A};
    assign b_ext = {{WIDTH{1'b0}}, B};
    assign sh    = B[SHW-1:0];

    // Rotation by shifting a doubled copy of A: the upper half of a left shift
    // and the lower half of a right shift are the rotated operand.
    assign dbl      = {A, A};
    assign rol_full = dbl << sh;
    assign ror_full = dbl >> sh;

    always_comb begin
        result_d = '0;
        unique case (Op)
            OP_ADD:  result_d = a_ext + b_ext;
            OP_SUB:  result_d = a_ext - b_ext;
            OP_MUL:  result_d = a_ext * b_ext;
            OP_DIV:  result_d = (B == '0) ? {RW{1'b1}} : (a_ext / b_ext);
            OP_MOD:  result_d = (B == '0) ? a_ext : (a_ext % b_ext);
            OP_AND:  result_d = {{WIDTH{1'b0}}, A & B};
            OP_OR:   result_d = {{WIDTH{1'b0}}, A | B};
            OP_XOR:  result_d = {{WIDTH{1'b0}}, A ^ B};
            OP_NAND: result_d = {{WIDTH{1'b0}}, ~(A & B)};
            OP_NOR:  result_d = {{WIDTH{1'b0}}, ~(A | B)};
            OP_SHL:  result_d = a_ext << sh;
            OP_SHR:  result_d = a_ext >> sh;
            OP_ROL:  result_d = {{WIDTH{1'b0}}, rol_full[RW-1:WIDTH]};
            OP_ROR:  result_d = {{WIDTH{1'b0}}, ror_full[WIDTH-1:0]};
            OP_EQ:   result_d = {{(RW-1){1'b0}}, (A == B)};
            OP_GT:   result_d = {{(RW-1){1'b0}}, (A > B)};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign Result = result_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic        clk;
    logic        reset;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  Op;
    logic [15:0] Result;

    int n_chk;
    int n_pass;

    alu_core #(.WIDTH(8)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .Op     (Op),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 16'h%04h, expected 16'h%04h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp);
        Op = op;
        A  = a;
        B  = b;
        @(posedge clk);
        #1;
        chk_val(tag, Result, exp);
    endtask

    logic [3:0]  t_op  [16];
    logic [7:0]  t_a   [16];
    logic [7:0]  t_b   [16];
    logic [15:0] t_exp [16];

    initial begin
        t_op[0]  = 4'd0;  t_a[0]  = 8'd10;  t_b[0]  = 8'd20;  t_exp[0]  = 16'h001E;
        t_op[1]  = 4'd1;  t_a[1]  = 8'd20;  t_b[1]  = 8'd10;  t_exp[1]  = 16'h000A;
        t_op[2]  = 4'd2;  t_a[2]  = 8'd16;  t_b[2]  = 8'd16;  t_exp[2]  = 16'h0100;
        t_op[3]  = 4'd3;  t_a[3]  = 8'd255; t_b[3]  = 8'd16;  t_exp[3]  = 16'h000F;
        t_op[4]  = 4'd4;  t_a[4]  = 8'd50;  t_b[4]  = 8'd16;  t_exp[4]  = 16'h0002;
        t_op[5]  = 4'd5;  t_a[5]  = 8'hF0;  t_b[5]  = 8'h3C;  t_exp[5]  = 16'h0030;
        t_op[6]  = 4'd6;  t_a[6]  = 8'hF0;  t_b[6]  = 8'h0F;  t_exp[6]  = 16'h00FF;
        t_op[7]  = 4'd7;  t_a[7]  = 8'hFF;  t_b[7]  = 8'h0F;  t_exp[7]  = 16'h00F0;
        t_op[8]  = 4'd8;  t_a[8]  = 8'hF0;  t_b[8]  = 8'h0F;  t_exp[8]  = 16'h00FF;
        t_op[9]  = 4'd9;  t_a[9]  = 8'h0F;  t_b[9]  = 8'h30;  t_exp[9]  = 16'h00C0;
        t_op[10] = 4'd10; t_a[10] = 8'hFF;  t_b[10] = 8'd7;   t_exp[10] = 16'h7F80;
        t_op[11] = 4'd11; t_a[11] = 8'h80;  t_b[11] = 8'd7;   t_exp[11] = 16'h0001;
        t_op[12] = 4'd12; t_a[12] = 8'h12;  t_b[12] = 8'd4;   t_exp[12] = 16'h0021;
        t_op[13] = 4'd13; t_a[13] = 8'h03;  t_b[13] = 8'd1;   t_exp[13] = 16'h0081;
        t_op[14] = 4'd14; t_a[14] = 8'd5;   t_b[14] = 8'd6;   t_exp[14] = 16'h0000;
        t_op[15] = 4'd15; t_a[15] = 8'd200; t_b[15] = 8'd100; t_exp[15] = 16'h0001;
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;

        // Reset held across two edges while a multiply is presented.
        reset = 1'b0;
        A     = 8'hFF;
        B     = 8'hFF;
        Op    = 4'd2;
        @(posedge clk);
        #1;
        chk_val("reset_edge1", Result, 16'h0000);
        @(posedge clk);
        #1;
        chk_val("reset_edge2", Result, 16'h0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_val("first_after_reset", Result, 16'hFE01);

        run_op("add",        4'd0,  8'd200, 8'd100, 16'h012C);
        run_op("sub_borrow", 4'd1,  8'd5,   8'd7,   16'hFFFE);
        run_op("mul_max",    4'd2,  8'd255, 8'd255, 16'hFE01);
        run_op("div",        4'd3,  8'd100, 8'd7,   16'd14);
        run_op("mod",        4'd4,  8'd100, 8'd7,   16'd2);
        run_op("div_zero",   4'd3,  8'd9,   8'd0,   16'hFFFF);
        run_op("mod_zero",   4'd4,  8'd9,   8'd0,   16'd9);
        run_op("and",        4'd5,  8'hA5,  8'h0F,  16'h0005);
        run_op("nand",       4'd8,  8'hA5,  8'h0F,  16'h00FA);
        run_op("xor",        4'd7,  8'hA5,  8'h0F,  16'h00AA);
        run_op("shl",        4'd10, 8'h81,  8'd3,   16'h0408);
        run_op("shr_hi_b",   4'd11, 8'h80,  8'hF9,  16'h0040);
        run_op("rol",        4'd12, 8'h81,  8'd1,   16'h0003);
        run_op("ror",        4'd13, 8'h01,  8'd1,   16'h0080);
        run_op("eq",         4'd14, 8'd42,  8'd42,  16'h0001);
        run_op("gt_false",   4'd15, 8'd3,   8'd4,   16'h0000);
        run_op("gt_true",    4'd15, 8'd4,   8'd3,   16'h0001);

        // Back-to-back stream: new inputs every cycle, all opcodes.
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("stream_op%0d", i), t_op[i], t_a[i], t_b[i], t_exp[i]);
        end

        // Reset mid-stream discards the operation sampled on the reset edge.
        reset = 1'b0;
        run_op("mid_reset",  4'd0,  8'd1,   8'd1,   16'h0000);
        reset = 1'b1;
        run_op("post_reset", 4'd0,  8'd1,   8'd2,   16'h0003);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
